// File: rtl/multicycle_ctl.sv
// Main controller for the multicycle RV32I core: sequences
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a req/ack memory handshake.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   ce             controller enable; 0 freezes state and counters
//   opcode         instr[6:0], valid from DECODE to end of instruction
//   branch_taken   ALU compare result, valid in EXECUTE
//   mem_ack        completion of the current memory request
//   fetch_en       instruction register load enable
//   mem_req/mem_we memory request / write
//   instrdec_ce    decoder enable
//   alu_ce         ALU enable
//   regfile_we     register write strobe
//   pc_inc/pc_load PC <= PC+4 / PC <= ALU target
//   retire         one-cycle pulse per completed instruction
//   retired_cnt    retired-instruction count (wraps)
//   trap           controller halted
//   trap_cause     00 none, 01 memory timeout, 10 illegal opcode
//   state_o        debug state: 0 RESET, 1 FETCH, 2 DECODE,
//                  3 EXECUTE, 4 MEM, 5 WRITEBACK, 6 TRAP
module multicycle_ctl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TMO_W       = 8,
   parameter int unsigned RET_CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic [6:0]           opcode,
   input  logic                 branch_taken,
   input  logic                 mem_ack,
   output logic                 fetch_en,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 instrdec_ce,
   output logic                 alu_ce,
   output logic                 regfile_we,
   output logic                 pc_inc,
   output logic                 pc_load,
   output logic                 retire,
   output logic [RET_CNT_W-1:0] retired_cnt,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [3:0]           state_o
);

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXECUTE   = 4'd3,
      S_MEM       = 4'd4,
      S_WRITEBACK = 4'd5,
      S_TRAP      = 4'd6
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   state_t             state, state_n;
   logic [TMO_W-1:0]   wait_cnt, wait_n;
   logic [1:0]         cause_n;
   logic               is_lui, is_jump, is_branch;
   logic               is_load, is_store, is_legal;
   logic               timeout_hit;

   // Raw strobes before ce gating
   logic dec_r, alu_r, rf_r, inc_r, load_r, ret_r;

   assign is_lui    = (opcode == OP_LUI);
   assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_legal  = is_lui || is_jump || is_branch || is_load
                   || is_store || (opcode == OP_AUIPC)
                   || (opcode == OP_IMM) || (opcode == OP_OP);

   // A zero MEM_TIMEOUT disables the watchdog entirely
   assign timeout_hit = (MEM_TIMEOUT != 0)
                     && (wait_cnt == TMO_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RESET;
         wait_cnt    <= '0;
         retired_cnt <= '0;
         trap_cause  <= 2'b00;
      end else if (ce) begin
         state      <= state_n;
         wait_cnt   <= wait_n;
         trap_cause <= cause_n;
         if (retire)
            retired_cnt <= retired_cnt + RET_CNT_W'(1);
      end
   end

   always_comb begin
      state_n  = state;
      wait_n   = '0;
      cause_n  = trap_cause;
      fetch_en = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      trap     = 1'b0;
      dec_r    = 1'b0;
      alu_r    = 1'b0;
      rf_r     = 1'b0;
      inc_r    = 1'b0;
      load_r   = 1'b0;
      ret_r    = 1'b0;
      unique case (state)
         S_RESET: state_n = S_FETCH;
         S_FETCH: begin
            fetch_en = 1'b1;
            mem_req  = 1'b1;
            if (mem_ack) begin
               state_n = S_DECODE;
            end else if (timeout_hit) begin
               state_n = S_TRAP;
               cause_n = 2'b01;
            end else begin
               wait_n = wait_cnt + TMO_W'(1);
            end
         end
         S_DECODE: begin
            dec_r = 1'b1;
            if (!is_legal) begin
               state_n = S_TRAP;
               cause_n = 2'b10;
            end else begin
               state_n = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            alu_r = !is_lui;
            if (is_load || is_store) begin
               state_n = S_MEM;
            end else if (is_branch) begin
               load_r  = branch_taken;
               inc_r   = !branch_taken;
               ret_r   = 1'b1;
               state_n = S_FETCH;
            end else begin
               state_n = S_WRITEBACK;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (mem_ack) begin
               if (is_store) begin
                  inc_r   = 1'b1;
                  ret_r   = 1'b1;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_WRITEBACK;
               end
            end else if (timeout_hit) begin
               state_n = S_TRAP;
               cause_n = 2'b01;
            end else begin
               wait_n = wait_cnt + TMO_W'(1);
            end
         end
         S_WRITEBACK: begin
            rf_r    = 1'b1;
            load_r  = is_jump;
            inc_r   = !is_jump;
            ret_r   = 1'b1;
            state_n = S_FETCH;
         end
         S_TRAP: trap = 1'b1;
         default: state_n = S_RESET;
      endcase
   end

   // Memory strobes stay up while frozen so an open request persists
   assign instrdec_ce = ce && dec_r;
   assign alu_ce      = ce && alu_r;
   assign regfile_we  = ce && rf_r;
   assign pc_inc      = ce && inc_r;
   assign pc_load     = ce && load_r;
   assign retire      = ce && ret_r;
   assign state_o     = state;

endmodule

// File: tb/tb_multicycle_ctl.sv
// Self-checking bench for multicycle_ctl: a transaction-level model
// expands each instruction into its expected per-cycle outputs.
module tb_multicycle_ctl;

   localparam logic [3:0] ST_RST = 4'd0;
   localparam logic [3:0] ST_FET = 4'd1;
   localparam logic [3:0] ST_DEC = 4'd2;
   localparam logic [3:0] ST_EXE = 4'd3;
   localparam logic [3:0] ST_MEM = 4'd4;
   localparam logic [3:0] ST_WB  = 4'd5;
   localparam logic [3:0] ST_TRP = 4'd6;

   localparam logic [9:0] FE  = 10'h200;
   localparam logic [9:0] MR  = 10'h100;
   localparam logic [9:0] MW  = 10'h080;
   localparam logic [9:0] DEC = 10'h040;
   localparam logic [9:0] ALU = 10'h020;
   localparam logic [9:0] RF  = 10'h010;
   localparam logic [9:0] PCI = 10'h008;
   localparam logic [9:0] PCL = 10'h004;
   localparam logic [9:0] RET = 10'h002;
   localparam logic [9:0] TRP = 10'h001;

   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] AUIPC = 7'b0010111;
   localparam logic [6:0] JAL   = 7'b1101111;
   localparam logic [6:0] JALR  = 7'b1100111;
   localparam logic [6:0] BR    = 7'b1100011;
   localparam logic [6:0] LD    = 7'b0000011;
   localparam logic [6:0] STO   = 7'b0100011;
   localparam logic [6:0] ADDI  = 7'b0010011;
   localparam logic [6:0] OPR   = 7'b0110011;
   localparam logic [6:0] BAD   = 7'b1111111;

   typedef struct {
      bit         rst, ce, ack, taken;
      logic [6:0] op;
      bit         chk;
      logic [3:0] st;
      logic [9:0] sb;
      logic [3:0] cnt;
      logic [1:0] cause;
      bit         pin;
      logic [3:0] pin_st;
      logic [3:0] pin_cnt;
   } rec_t;

   rec_t q[$];
   logic [3:0] m_cnt;
   logic [1:0] m_cause;

   logic       clk = 1'b0;
   logic       reset = 1'b1, ce = 1'b1, mem_ack = 1'b0;
   logic       branch_taken = 1'b0;
   logic [6:0] opcode = ADDI;
   logic       fetch_en, mem_req, mem_we, instrdec_ce, alu_ce;
   logic       regfile_we, pc_inc, pc_load, retire, trap;
   logic [3:0] retired_cnt;
   logic [1:0] trap_cause;
   logic [3:0] state_o;

   int total = 0, bad = 0, cur = 0;
   bit run = 1'b0;

   always #5 clk = ~clk;

   multicycle_ctl #(
      .MEM_TIMEOUT(16), .TMO_W(8), .RET_CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce), .opcode(opcode),
      .branch_taken(branch_taken), .mem_ack(mem_ack),
      .fetch_en(fetch_en), .mem_req(mem_req), .mem_we(mem_we),
      .instrdec_ce(instrdec_ce), .alu_ce(alu_ce),
      .regfile_we(regfile_we), .pc_inc(pc_inc),
      .pc_load(pc_load), .retire(retire),
      .retired_cnt(retired_cnt), .trap(trap),
      .trap_cause(trap_cause), .state_o(state_o)
   );

   task automatic push(input bit rst, input bit c, input bit a,
                       input bit tk, input logic [6:0] op,
                       input bit chk, input logic [3:0] st,
                       input logic [9:0] sb);
      rec_t r;
      r.rst = rst; r.ce = c; r.ack = a; r.taken = tk; r.op = op;
      r.chk = chk; r.st = st; r.sb = sb;
      r.cnt = m_cnt; r.cause = m_cause;
      r.pin = 1'b0; r.pin_st = '0; r.pin_cnt = '0;
      q.push_back(r);
      if ((sb & RET) != 0) m_cnt = m_cnt + 4'd1;
   endtask

   task automatic pin_at(input int idx, input logic [3:0] st,
                         input logic [3:0] cnt);
      q[idx].pin = 1'b1;
      q[idx].pin_st = st;
      q[idx].pin_cnt = cnt;
   endtask

   task automatic do_reset(input bit c);
      push(1'b1, c, 1'b0, 1'b0, ADDI, 1'b0, ST_RST, '0);
      m_cnt = '0;
      m_cause = 2'b00;
      push(1'b0, 1'b1, 1'b0, 1'b0, ADDI, 1'b1, ST_RST, '0);
   endtask

   task automatic fetch_phase(input logic [6:0] op, input int fw);
      for (int i = 0; i < fw; i++)
         push(1'b0, 1'b1, 1'b0, 1'b0, op, 1'b1, ST_FET, FE | MR);
      push(1'b0, 1'b1, 1'b1, 1'b0, op, 1'b1, ST_FET, FE | MR);
   endtask

   task automatic trap_cycles(input int n, input bit toggle);
      for (int i = 0; i < n; i++)
         push(1'b0, 1'b1, toggle & i[0], 1'b0, BAD, 1'b1, ST_TRP, TRP);
   endtask

   task automatic instr(input logic [6:0] op, input int fw,
                        input int mw, input bit tk,
                        input int p_at, input int p_len);
      logic [9:0] sb, we;
      fetch_phase(op, fw);
      push(1'b0, 1'b1, 1'b0, 1'b0, op, 1'b1, ST_DEC, DEC);
      sb = (op == LUI) ? 10'h0 : ALU;
      if (op == BR) begin
         sb = sb | RET | (tk ? PCL : PCI);
         push(1'b0, 1'b1, 1'b0, tk, op, 1'b1, ST_EXE, sb);
         return;
      end
      push(1'b0, 1'b1, 1'b0, 1'b0, op, 1'b1, ST_EXE, sb);
      if (op == LD || op == STO) begin
         we = (op == STO) ? MW : 10'h0;
         for (int i = 0; i < mw; i++) begin
            if (p_len > 0 && i == p_at)
               for (int k = 0; k < p_len; k++)
                  push(1'b0, 1'b0, 1'b1, 1'b0, op, 1'b1, ST_MEM, MR | we);
            push(1'b0, 1'b1, 1'b0, 1'b0, op, 1'b1, ST_MEM, MR | we);
         end
         if (op == STO) begin
            push(1'b0, 1'b1, 1'b1, 1'b0, op, 1'b1, ST_MEM,
                 MR | MW | PCI | RET);
            return;
         end
         push(1'b0, 1'b1, 1'b1, 1'b0, op, 1'b1, ST_MEM, MR);
      end
      sb = RF | RET | ((op == JAL || op == JALR) ? PCL : PCI);
      push(1'b0, 1'b1, 1'b0, 1'b0, op, 1'b1, ST_WB, sb);
   endtask

   task automatic build();
      m_cnt = '0;
      m_cause = 2'b00;
      do_reset(1'b1);
      repeat (3) instr(ADDI, 0, 0, 1'b0, 0, 0);
      instr(LD, 0, 3, 1'b0, 0, 0);
      instr(STO, 0, 0, 1'b0, 0, 0);
      instr(BR, 0, 0, 1'b1, 0, 0);
      instr(BR, 0, 0, 1'b0, 0, 0);
      instr(JAL, 0, 0, 1'b0, 0, 0);
      instr(JALR, 1, 0, 1'b0, 0, 0);
      instr(LUI, 0, 0, 1'b0, 0, 0);
      instr(AUIPC, 0, 0, 1'b0, 0, 0);
      instr(OPR, 0, 0, 1'b0, 0, 0);
      instr(ADDI, 15, 0, 1'b0, 0, 0);
      instr(LD, 0, 15, 1'b0, 10, 5);
      instr(STO, 2, 4, 1'b0, 0, 0);
      repeat (16)
         push(1'b0, 1'b1, 1'b0, 1'b0, ADDI, 1'b1, ST_FET, FE | MR);
      m_cause = 2'b01;
      trap_cycles(5, 1'b1);
      do_reset(1'b0);
      fetch_phase(BAD, 0);
      push(1'b0, 1'b1, 1'b0, 1'b0, BAD, 1'b1, ST_DEC, DEC);
      m_cause = 2'b10;
      trap_cycles(20, 1'b1);
      do_reset(1'b1);
      pin_at(q.size() - 1, ST_RST, 4'd0);
      fetch_phase(STO, 0);
      push(1'b0, 1'b1, 1'b0, 1'b0, STO, 1'b1, ST_DEC, DEC);
      push(1'b0, 1'b1, 1'b0, 1'b0, STO, 1'b1, ST_EXE, ALU);
      repeat (16)
         push(1'b0, 1'b1, 1'b0, 1'b0, STO, 1'b1, ST_MEM, MR | MW);
      m_cause = 2'b01;
      trap_cycles(3, 1'b0);
      do_reset(1'b1);
      repeat (17) instr(ADDI, 0, 0, 1'b0, 0, 0);
      push(1'b0, 1'b1, 1'b0, 1'b0, ADDI, 1'b1, ST_FET, FE | MR);
      pin_at(q.size() - 1, ST_FET, 4'd1);
      // Hand-derived anchors for the opening instructions
      pin_at(1, ST_RST, 4'd0);
      pin_at(5, ST_WB, 4'd0);
      pin_at(9, ST_WB, 4'd1);
      pin_at(14, ST_FET, 4'd3);
      pin_at(21, ST_WB, 4'd3);
      pin_at(22, ST_FET, 4'd4);
      pin_at(25, ST_MEM, 4'd4);
      pin_at(26, ST_FET, 4'd5);
      pin_at(29, ST_FET, 4'd6);
   endtask

   task automatic check(input string name, input int act,
                        input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h",
                  name, cur, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (run && q[cur].chk) begin
         check("state", int'(state_o), int'(q[cur].st));
         check("strobes",
               int'({fetch_en, mem_req, mem_we, instrdec_ce,
                     alu_ce, regfile_we, pc_inc, pc_load,
                     retire, trap}),
               int'(q[cur].sb));
         check("retired_cnt", int'(retired_cnt), int'(q[cur].cnt));
         check("trap_cause", int'(trap_cause), int'(q[cur].cause));
         check("pc_excl", int'(pc_inc & pc_load), 0);
         if (q[cur].pin) begin
            check("pin_state", int'(state_o), int'(q[cur].pin_st));
            check("pin_cnt", int'(retired_cnt), int'(q[cur].pin_cnt));
         end
      end
   end

   initial begin
      build();
      for (int i = 0; i < q.size(); i++) begin
         @(posedge clk);
         #1;
         cur = i;
         reset = q[i].rst;
         ce = q[i].ce;
         mem_ack = q[i].ack;
         branch_taken = q[i].taken;
         opcode = q[i].op;
         run = 1'b1;
      end
      @(posedge clk);
      #1;
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
